// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   DMEM_DEPTH   - default number of 32-bit data-memory words
//   dmem_state_e - arbiter FSM state encoding (IDLE=0, ISSUE=1, RESP=2)
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin selector (purely combinational).
// Ports:
//   req0, req1   - requests from port 0 / port 1
//   last_served  - port that received the most recent grant
//   grant_valid  - at least one request is present
//   grant_id     - winning port (0 or 1); only meaningful with grant_valid
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            // Contention: the port that was not served last goes next.
            grant_id = ~last_served;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port 32-bit data memory.
// Each granted access takes three cycles: IDLE (grant) -> ISSUE (memory
// access) -> RESP (one-cycle ack to the owner).
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0   - requester 0 (core load/store), held until ack0
//   req1/we1/addr1/wdata1   - requester 1 (debug/loader), held until ack1
//   ack0/ack1               - one-cycle completion pulses
//   rdata0/rdata1           - last read data per port, updated on read acks
//   err0/err1               - address out of range, valid with ack
//   mem_we/mem_re           - data memory write / read enables
//   mem_addr/mem_wdata      - data memory address / write data
//   mem_rdata               - data memory read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [31:0]   wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata1,
    output logic          ack0,
    output logic [31:0]   rdata0,
    output logic          err0,
    output logic          ack1,
    output logic [31:0]   rdata1,
    output logic          err1,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    // Widened compare so that DEPTH == 2**AW does not wrap to zero.
    localparam logic [63:0] Depth64 = 64'(DEPTH);

    dmem_state_e   state_q, state_d;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          last_q;
    logic [31:0]   rdata0_q, rdata1_q;

    logic grant_valid;
    logic grant_id;
    logic grant;
    logic in_range;

    dmem_rr_pick u_rr_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign in_range = (64'(addr_q) < Depth64);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; all derived from reset registers so they clear asynchronously.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = (state_q == StIssue) && we_q && in_range;
        mem_re    = (state_q == StIssue) && !we_q && in_range;
        ack0      = (state_q == StResp) && !owner_q;
        ack1      = (state_q == StResp) && owner_q;
        err0      = ack0 && !in_range;
        err1      = ack1 && !in_range;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b1;   // port 0 wins the first contention
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_id;
                last_q  <= grant_id;
                we_q    <= grant_id ? we1    : we0;
                addr_q  <= grant_id ? addr1  : addr0;
                wdata_q <= grant_id ? wdata1 : wdata0;
            end
        end
    end

    // Read data is captured at the edge ending ISSUE so it is visible with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == StIssue && !we_q) begin
            if (!owner_q) begin
                rdata0_q <= in_range ? mem_rdata : '0;
            end else begin
                rdata1_q <= in_range ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of single-port transactions,
// hand-written round-robin and reset-abort sequences, and a randomized phase
// compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0  = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1;
    logic [31:0]   rdata0, rdata1;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .err0      (err0),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .err1      (err1),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory: writes at posedge, read data refreshed on negedge.
    logic [31:0] mem [DEPTH];
    logic        mem_clear = 1'b0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Protocol monitor sampled mid-cycle.
    logic pa0 = 1'b0, pa1 = 1'b0, prev_en = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pa0 = 1'b0; pa1 = 1'b0; prev_en = 1'b0;
        end else begin
            check("mon_ack_excl", 32'(ack0 & ack1), 32'd0);
            check("mon_en_excl", 32'(mem_we & mem_re), 32'd0);
            check("mon_ack0_one_cycle", 32'(ack0 & pa0), 32'd0);
            check("mon_ack1_one_cycle", 32'(ack1 & pa1), 32'd0);
            check("mon_ack_after_issue", 32'(prev_en & ~(ack0 | ack1)), 32'd0);
            check("mon_err_needs_ack", 32'((err0 & ~ack0) | (err1 & ~ack1)), 32'd0);
            pa0 = ack0; pa1 = ack1; prev_en = mem_we | mem_re;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input logic clear);
        req0 = 1'b0; req1 = 1'b0;
        #2 rst_n = 1'b0;
        mem_clear = clear;
        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single-port transaction, started and ended at posedge+1 with the FSM idle.
    task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rdata, output int we_seen);
        if (!port) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        lat = 0; we_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_we) we_seen++;
            if ((!port && ack0) || (port && ack1)) begin
                lat = c;
                break;
            end
        end
        err   = port ? err1 : err0;
        rdata = port ? rdata1 : rdata0;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic gen_req(output logic r, output logic w, output logic [AW-1:0] a,
                           output logic [31:0] d);
        int unsigned sel;
        r   = ($urandom_range(0, 9) < 6);
        w   = 1'($urandom_range(0, 1));
        d   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = AW'($urandom_range(0, 15));
        else if (sel == 7) a = AW'(255);
        else if (sel == 8) a = AW'(256 + $urandom_range(0, 50));
        else               a = AW'($urandom);
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_we;
    } vec_t;

    vec_t vecs[13];

    // Reference model state for the randomized phase.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd [2];

    initial begin
        int          lat, we_seen, n;
        logic        err;
        logic [31:0] rd;
        int          ack_cyc [4];
        logic        ack_port [4];
        int          m_left;
        logic        m_last, t_port, t_we, inr, w;
        logic [AW-1:0] t_addr;
        logic [31:0] t_wdata;
        logic [1:0]  exp_ack;
        logic        exp_err, exp_we, exp_re;
        logic        r, wv;
        logic [AW-1:0] av;
        logic [31:0] dv;

        vecs[0]  = '{1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 1'b0, 32'h0,        1};
        vecs[1]  = '{1'b0, 1'b0, 32'd5,   32'h0,        1'b0, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b1, 1'b1, 32'd10,  32'h12345678, 1'b0, 32'h0,        1};
        vecs[3]  = '{1'b0, 1'b0, 32'd10,  32'h0,        1'b0, 32'h12345678, 0};
        vecs[4]  = '{1'b1, 1'b1, 32'd300, 32'hCAFEF00D, 1'b1, 32'h0,        0};
        vecs[5]  = '{1'b1, 1'b0, 32'd10,  32'h0,        1'b0, 32'h12345678, 0};
        vecs[6]  = '{1'b0, 1'b0, 32'd300, 32'h0,        1'b1, 32'h0,        0};
        vecs[7]  = '{1'b0, 1'b1, 32'd255, 32'hA5A5A5A5, 1'b0, 32'h0,        1};
        vecs[8]  = '{1'b0, 1'b0, 32'd255, 32'h0,        1'b0, 32'hA5A5A5A5, 0};
        vecs[9]  = '{1'b1, 1'b1, 32'd256, 32'hFFFFFFFF, 1'b1, 32'h12345678, 0};
        vecs[10] = '{1'b0, 1'b0, 32'd5,   32'h0,        1'b0, 32'hDEADBEEF, 0};
        vecs[11] = '{1'b1, 1'b0, 32'd0,   32'h0,        1'b0, 32'h0,        0};
        vecs[12] = '{1'b0, 1'b0, 32'd44,  32'h0,        1'b0, 32'h0,        0};

        // Reset values, before any clock edge.
        #1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_err", 32'(err0 | err1), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_mem_en", 32'({mem_we, mem_re}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        do_reset(1'b1);

        foreach (vecs[i]) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rd, we_seen);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_mem_we_cycles", i), 32'(we_seen), 32'(vecs[i].exp_we));
        end

        // Simultaneous reads after reset: port 0 first, then strict alternation.
        do_reset(1'b0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd10;
        n = 0;
        for (int c = 1; c <= 16 && n < 4; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin
                ack_cyc[n]  = c;
                ack_port[n] = ack1;
                if (ack0) check("rr_rdata0", rdata0, 32'hDEADBEEF);
                if (ack1) check("rr_rdata1", rdata1, 32'h12345678);
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_ack_count", 32'(n), 32'd4);
        for (int k = 0; k < n; k++) begin
            check($sformatf("rr_port%0d", k), 32'(ack_port[k]), 32'(k % 2));
            check($sformatf("rr_cycle%0d", k), 32'(ack_cyc[k]), 32'(2 + 3 * k));
        end
        @(posedge clk); #1;

        // Reset during the ISSUE cycle of a write aborts it.
        do_txn(1'b0, 1'b1, 32'd20, 32'hAAAA5555, lat, err, rd, we_seen);
        check("abort_setup_latency", 32'(lat), 32'd2);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd20; wdata0 = 32'h0BADF00D;
        @(posedge clk); #1;
        check("abort_issue_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we | mem_re), 32'd0);
        check("abort_ack", 32'(ack0 | ack1), 32'd0);
        check("abort_rdata0", rdata0, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        req0 = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            check("post_abort_quiet", 32'({mem_we, mem_re, ack0, ack1}), 32'd0);
            @(posedge clk); #1;
        end
        do_txn(1'b0, 1'b0, 32'd20, 32'h0, lat, err, rd, we_seen);
        check("abort_kept_old_data", rd, 32'hAAAA5555);

        // Randomized traffic against the reference model.
        do_reset(1'b1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        m_left = 0; m_last = 1'b1;
        t_port = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; inr = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            exp_ack = 2'b00; exp_err = 1'b0; exp_we = 1'b0; exp_re = 1'b0;
            if (m_left == 0) begin
                if (req0 || req1) begin
                    if (req0 && req1) w = ~m_last;
                    else              w = req1;
                    m_last  = w;
                    t_port  = w;
                    t_we    = w ? we1 : we0;
                    t_addr  = w ? addr1 : addr0;
                    t_wdata = w ? wdata1 : wdata0;
                    inr     = (t_addr < AW'(DEPTH));
                    exp_we  = t_we && inr;
                    exp_re  = !t_we && inr;
                    m_left  = 2;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    exp_ack[t_port] = 1'b1;
                    exp_err = !inr;
                    if (!t_we)    exp_rd[t_port] = inr ? ref_mem[t_addr[7:0]] : 32'h0;
                    else if (inr) ref_mem[t_addr[7:0]] = t_wdata;
                end
            end
            check("rnd_ack0", 32'(ack0), 32'(exp_ack[0]));
            check("rnd_ack1", 32'(ack1), 32'(exp_ack[1]));
            check("rnd_err0", 32'(err0), 32'(exp_ack[0] & exp_err));
            check("rnd_err1", 32'(err1), 32'(exp_ack[1] & exp_err));
            check("rnd_rdata0", rdata0, exp_rd[0]);
            check("rnd_rdata1", rdata1, exp_rd[1]);
            check("rnd_mem_we", 32'(mem_we), 32'(exp_we));
            check("rnd_mem_re", 32'(mem_re), 32'(exp_re));
            if (exp_we || exp_re) check("rnd_mem_addr", mem_addr, t_addr);
            if (exp_we) check("rnd_mem_wdata", mem_wdata, t_wdata);

            // A port may change its request only when idle or just acked.
            if (!req0 || exp_ack[0]) begin
                gen_req(r, wv, av, dv);
                req0 = r; we0 = wv; addr0 = av; wdata0 = dv;
            end
            if (!req1 || exp_ack[1]) begin
                gen_req(r, wv, av, dv);
                req1 = r; we1 = wv; addr1 = av; wdata1 = dv;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit data-memory words addressable.
REQ-002 Parameter AW, default 32, requester/memory address width (word index).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  access request from requester 0 (core load/store) / requester 1 (debug/loader).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; held with req.
REQ-007 addr0, addr1  input  AW each  word address; held with req.
REQ-008 wdata0, wdata1  input  32 each  write data; held with req.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  output  32 each  read data, valid in ack cycle of a read.
REQ-011 err0, err1  output  1 each  out-of-range flag, valid with ack.
REQ-012 mem_we, mem_re  output  1 each  drive data memory write_enable / read_enable.
REQ-013 mem_addr  output  AW; mem_wdata  output  32; mem_rdata  input  32 (memory data_out).

Function
REQ-014 FSM states IDLE, ISSUE, RESP; one transaction per 3 cycles.
REQ-015 IDLE: at posedge, if any req high, arbitrate, latch owner/we/addr/wdata, go ISSUE; else stay IDLE.
REQ-016 Arbitration: single req wins; both req -> round-robin, winner is the port not served last; after reset port 0 has priority.
REQ-017 last_served pointer updates only when a grant is made.
REQ-018 ISSUE: mem_addr/mem_wdata from latched values; mem_we = latched we and in-range; mem_re = !we and in-range; go RESP next posedge.
REQ-019 Memory writes on posedge ending ISSUE, updates data_out on negedge within ISSUE; arbiter captures mem_rdata at posedge ending ISSUE.
REQ-020 RESP: ack of owner high exactly one cycle; owner rdata = captured word for reads; return to IDLE.
REQ-021 In-range: addr < DEPTH; out-of-range -> no mem_we/mem_re, err=1 with ack, rdata=0.
REQ-022 mem_we, mem_re, ack0/1, err0/1 low in IDLE and outside their defined cycles; mem_we and mem_re never both high.
REQ-023 rdataN holds last value until its next read ack; writes leave rdataN unchanged.
REQ-024 Requester must hold req/we/addr/wdata until ack; req still high in IDLE after ack counts as new request.
REQ-025 Non-owner req changes during ISSUE/RESP have no effect; it waits in IDLE arbitration.
REQ-026 Latency: req seen at posedge E0 -> ack high in cycle after E1 (2 cycles).

Reset
REQ-027 rst_n low: state IDLE, last_served = 1, all outputs 0, latched registers 0, immediately and asynchronously.
REQ-028 Reset mid-ISSUE/RESP aborts the transaction: no ack, mem_we drops immediately; memory contents written before reset are kept.
REQ-029 First grant possible at first posedge after rst_n deasserts.

Structure
REQ-030 Shared package holds FSM state encoding (2 bits: IDLE=0, ISSUE=1, RESP=2) and DMEM_DEPTH=256 default.
REQ-031 One sub-module natural: dmem_rr_pick (2-way round-robin select, combinational, from req0, req1, last_served).
REQ-032 Integration: top level instantiates dmem_arbiter in front of the single data memory; no other block drives memory enables.

Verification
REQ-033 req0 write addr 5 data 0xDEADBEEF, then req0 read addr 5 -> ack0 on each, read rdata0=0xDEADBEEF, err0=0.
REQ-034 req0 and req1 reads asserted together after reset -> port 0 served first, port 1 acked 3 cycles later; both held high -> alternate 0,1,0,1.
REQ-035 req1 write addr 300 (DEPTH 256) -> ack1 with err1=1, mem_we never high, prior contents unchanged.
REQ-036 req1 write addr 10 = 0x12345678, req0 read addr 10 -> rdata0=0x12345678.
REQ-037 rst_n low during ISSUE of write -> outputs 0 at once, no ack; after release idle with no req -> mem_we/mem_re stay 0.
REQ-038 Assertions throughout: ack one cycle, never ack0&ack1, never mem_we&mem_re, ack exactly 2 cycles after grant.
